// File: rtl/mnist_pkg.sv
// Shared types for the MNIST accelerator datapath.
// Holds bus widths, the result-writer FSM encoding and the pooled vector type.
package mnist_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int NUM_POOL_OUT   = 12;
  localparam int EXT_ADDR_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    WRITE,
    DONE
  } writer_state_t;

  typedef logic [NUM_POOL_OUT*DATA_WIDTH-1:0] pool_vec_t;

endpackage

// File: rtl/pool_vec_fifo.sv
// Two-entry vector FIFO between the pooling bus and the RAM serialiser.
// Push and pop may occur in the same cycle.
module pool_vec_fifo #(
  parameter int WIDTH = mnist_pkg::NUM_POOL_OUT * mnist_pkg::DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       cnt;

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/pool_result_writer.sv
// Drains pooled float32 vectors into an external RAM, one word per handshake.
// Two-slot buffering; frame_done pulses after the last vector of a frame.
module pool_result_writer #(
  parameter int DATA_WIDTH     = mnist_pkg::DATA_WIDTH,
  parameter int NUM_OUT        = mnist_pkg::NUM_POOL_OUT,
  parameter int FRAME_VECS     = 12,
  parameter int EXT_ADDR_WIDTH = mnist_pkg::EXT_ADDR_WIDTH,
  parameter int BASE_ADDR      = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          pool_valid,
  input  logic [NUM_OUT*DATA_WIDTH-1:0] pool_bus,
  output logic                          pool_ready,
  output logic [EXT_ADDR_WIDTH-1:0]     ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_data,
  output logic                          ram_we,
  input  logic                          ram_ready,
  output logic                          frame_done,
  output logic                          overflow
);

  import mnist_pkg::*;

  localparam int WW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int VW = $clog2(FRAME_VECS + 1);

  writer_state_t state;
  writer_state_t state_nxt;

  logic [NUM_OUT*DATA_WIDTH-1:0] head;
  logic [EXT_ADDR_WIDTH-1:0]     word_count;
  logic [WW-1:0]                 word_idx;
  logic [VW-1:0]                 cap_cnt;
  logic [VW-1:0]                 wr_cnt;
  logic [DATA_WIDTH-1:0]         word;

  logic live;
  logic push;
  logic pop;
  logic full;
  logic empty;
  logic accept;
  logic last_word;
  logic last_vec;

  assign live       = (state == ARMED) || (state == WRITE);
  assign pool_ready = live && !full && (cap_cnt < VW'(FRAME_VECS));
  assign push       = pool_valid && pool_ready;
  assign ram_we     = (state == WRITE) && !empty;
  assign accept     = ram_we && ram_ready;
  assign last_word  = (word_idx == WW'(NUM_OUT - 1));
  assign last_vec   = (wr_cnt == VW'(FRAME_VECS - 1));
  assign pop        = accept && last_word;
  assign frame_done = (state == DONE);

  // Outputs stay at zero whenever no write is being requested.
  assign ram_addr = ram_we ?
    EXT_ADDR_WIDTH'(BASE_ADDR) + word_count : '0;
  assign ram_data = ram_we ? word : '0;

  pool_vec_fifo #(
    .WIDTH(NUM_OUT * DATA_WIDTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .din  (pool_bus),
    .dout (head),
    .full (full),
    .empty(empty)
  );

  // Word 0 sits in the most significant slice of the bus.
  always_comb begin
    word = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (word_idx == WW'(k)) begin
        word = head[(NUM_OUT-k)*DATA_WIDTH-1 -: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (enable) state_nxt = ARMED;
      end
      ARMED: begin
        if (push) state_nxt = WRITE;
      end
      WRITE: begin
        if (pop) begin
          if (last_vec)          state_nxt = DONE;
          else if (full || push) state_nxt = WRITE;
          else                   state_nxt = ARMED;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      word_count <= '0;
      word_idx   <= '0;
      cap_cnt    <= '0;
      wr_cnt     <= '0;
      overflow   <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && enable) begin
        word_count <= '0;
        word_idx   <= '0;
        cap_cnt    <= '0;
        wr_cnt     <= '0;
      end else begin
        if (push) begin
          cap_cnt <= cap_cnt + VW'(1);
        end
        if (accept) begin
          word_count <= word_count + EXT_ADDR_WIDTH'(1);
          word_idx   <= last_word ? '0 : word_idx + WW'(1);
        end
        if (pop) begin
          wr_cnt <= wr_cnt + VW'(1);
        end
      end
      if (pool_valid && !pool_ready && live) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pool_result_writer.sv
// Scoreboard bench for pool_result_writer: two instances (base 0 and 4090)
// share stimulus; captured vectors become expected word streams.
module tb_pool_result_writer;

  localparam int DW = 32;
  localparam int NO = 12;
  localparam int AW = 12;
  localparam int FV = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          pool_valid;
  logic [NO*DW-1:0] pool_bus;
  logic          ram_ready;

  logic          pool_ready0, pool_ready1;
  logic [AW-1:0] ram_addr0, ram_addr1;
  logic [DW-1:0] ram_data0, ram_data1;
  logic          ram_we0, ram_we1;
  logic          frame_done0, frame_done1;
  logic          overflow0, overflow1;

  always #5 clk = ~clk;

  pool_result_writer #(.BASE_ADDR(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .pool_valid(pool_valid), .pool_bus(pool_bus),
    .pool_ready(pool_ready0), .ram_addr(ram_addr0),
    .ram_data(ram_data0), .ram_we(ram_we0),
    .ram_ready(ram_ready), .frame_done(frame_done0),
    .overflow(overflow0)
  );

  pool_result_writer #(.BASE_ADDR(4090)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .pool_valid(pool_valid), .pool_bus(pool_bus),
    .pool_ready(pool_ready1), .ram_addr(ram_addr1),
    .ram_data(ram_data1), .ram_we(ram_we1),
    .ram_ready(ram_ready), .frame_done(frame_done1),
    .overflow(overflow1)
  );

  typedef struct {
    int          off;
    logic [31:0] d;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int exp_off = 0;
  int wr_seen = 0;
  int fd_count = 0;
  int mode = 0;
  int phase = 0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // RAM back-pressure patterns
  always @(posedge clk) begin
    #1;
    phase = (phase + 1) % 4;
    case (mode)
      0:       ram_ready = 1'b1;
      1:       ram_ready = (phase == 0) || (phase == 3);
      2:       ram_ready = 1'($urandom_range(0, 1));
      default: ram_ready = 1'b0;
    endcase
  end

  // Each accepted vector expands into NO expected words, MSB slice first.
  always @(negedge clk) begin
    if (rst_n && pool_valid && pool_ready0) begin
      for (int k = 0; k < NO; k++) begin
        exp_t e;
        e.off = exp_off;
        e.d   = pool_bus[(NO-k)*DW-1 -: DW];
        q.push_back(e);
        exp_off++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (frame_done0) fd_count++;
      if (prev_stall && ram_we0) begin
        chk("hold_addr", 64'(ram_addr0), 64'(prev_addr));
        chk("hold_data", 64'(ram_data0), 64'(prev_data));
      end
      if (ram_we0 && ram_ready) begin
        wr_seen++;
        if (q.size() == 0) begin
          chk("unexpected_write", 64'(ram_addr0), 64'hFFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("addr_base0", 64'(ram_addr0), 64'(e.off % 4096));
          chk("addr_base4090", 64'(ram_addr1),
              64'((4090 + e.off) % 4096));
          chk("data0", 64'(ram_data0), 64'(e.d));
          chk("data1", 64'(ram_data1), 64'(e.d));
        end
      end
      prev_stall = ram_we0 && !ram_ready;
      prev_addr  = ram_addr0;
      prev_data  = ram_data0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    enable  = 1'b1;
    exp_off = 0;
    cyc(1);
    enable  = 1'b0;
  endtask

  task automatic rand_vec(output logic [NO*DW-1:0] v);
    for (int k = 0; k < NO; k++) v[k*DW +: DW] = $urandom;
  endtask

  task automatic send_vec(input logic [NO*DW-1:0] v);
    bit ok;
    ok = 1'b0;
    pool_valid = 1'b1;
    pool_bus   = v;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (pool_ready0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    pool_valid = 1'b0;
    if (!ok) chk("send_timeout", 64'(ok), 64'(1));
  endtask

  task automatic wait_drain(input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !ram_we0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 64'(q.size()), 64'(0));
    cyc(3);
  endtask

  initial begin
    logic [NO*DW-1:0] v;
    int w0;
    int f0;
    bit found;

    rst_n      = 1'b0;
    enable     = 1'b0;
    pool_valid = 1'b0;
    pool_bus   = '0;
    ram_ready  = 1'b1;
    cyc(3);
    @(negedge clk);
    chk("rst_we", 64'(ram_we0), 64'(0));
    chk("rst_addr0", 64'(ram_addr0), 64'(0));
    chk("rst_addr1", 64'(ram_addr1), 64'(0));
    chk("rst_data", 64'(ram_data0), 64'(0));
    chk("rst_ready", 64'(pool_ready0), 64'(0));
    chk("rst_done", 64'(frame_done0), 64'(0));
    chk("rst_ovf", 64'(overflow0), 64'(0));
    cyc(1);
    rst_n = 1'b1;
    cyc(1);

    // single vector, then fill the rest of the frame
    w0 = wr_seen;
    f0 = fd_count;
    start_frame();
    for (int k = 0; k < NO; k++)
      v[(NO-k)*DW-1 -: DW] = 32'h3F80_0000 + 32'(k);
    send_vec(v);
    @(negedge clk);
    chk("we_latency", 64'(ram_we0), 64'(1));
    chk("first_addr", 64'(ram_addr0), 64'(0));
    chk("first_data", 64'(ram_data0), 64'h3F80_0000);
    cyc(1);
    wait_drain(200);
    chk("t1_writes", 64'(wr_seen - w0), 64'(NO));
    for (int i = 1; i < FV; i++) begin
      rand_vec(v);
      send_vec(v);
    end
    wait_drain(1000);
    chk("frame_writes", 64'(wr_seen - w0), 64'(NO * FV));
    chk("frame_done_cnt", 64'(fd_count - f0), 64'(1));
    @(negedge clk);
    chk("ready_after_frame", 64'(pool_ready0), 64'(0));
    cyc(1);

    // stalled RAM: 1,0,0,1 pattern
    mode = 1;
    w0 = wr_seen;
    f0 = fd_count;
    start_frame();
    for (int i = 0; i < FV; i++) begin
      rand_vec(v);
      send_vec(v);
    end
    wait_drain(3000);
    chk("stall_writes", 64'(wr_seen - w0), 64'(NO * FV));
    chk("stall_done_cnt", 64'(fd_count - f0), 64'(1));

    // overflow with RAM blocked
    mode = 3;
    cyc(1);
    start_frame();
    pool_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_vec(v);
      pool_bus = v;
      @(negedge clk);
      chk("ovf_ready", 64'(pool_ready0), 64'(i < 2));
      cyc(1);
    end
    pool_valid = 1'b0;
    @(negedge clk);
    chk("ovf_set", 64'(overflow0), 64'(1));
    chk("ovf_full_ready", 64'(pool_ready0), 64'(0));
    repeat (5) @(negedge clk);
    chk("ovf_sticky", 64'(overflow0), 64'(1));
    cyc(1);

    // reset while word 5 is on the bus
    mode = 0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (ram_we0 && ram_addr0 == AW'(5)) begin
        found = 1'b1;
        break;
      end
    end
    chk("word5_seen", 64'(found), 64'(1));
    rst_n = 1'b0;
    cyc(1);
    q.delete();
    exp_off = 0;
    @(negedge clk);
    chk("mid_rst_we", 64'(ram_we0), 64'(0));
    chk("mid_rst_ovf", 64'(overflow0), 64'(0));
    chk("mid_rst_ready", 64'(pool_ready0), 64'(0));
    cyc(1);
    rst_n = 1'b1;
    pool_valid = 1'b1;
    cyc(4);
    pool_valid = 1'b0;
    @(negedge clk);
    chk("idle_valid_ovf", 64'(overflow0), 64'(0));
    chk("idle_ready", 64'(pool_ready0), 64'(0));
    cyc(1);
    w0 = wr_seen;
    start_frame();
    rand_vec(v);
    send_vec(v);
    wait_drain(200);
    chk("restart_writes", 64'(wr_seen - w0), 64'(NO));
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    // random back-pressure, gaps, ignored enable mid-frame
    mode = 2;
    w0 = wr_seen;
    f0 = fd_count;
    start_frame();
    for (int i = 0; i < FV; i++) begin
      rand_vec(v);
      send_vec(v);
      if (i == 3) begin
        enable = 1'b1;
        cyc(1);
        enable = 1'b0;
      end
      cyc($urandom_range(0, 20));
    end
    wait_drain(5000);
    chk("rand_writes", 64'(wr_seen - w0), 64'(NO * FV));
    chk("rand_done_cnt", 64'(fd_count - f0), 64'(1));
    chk("q_empty", 64'(q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
